tff_count_ctrl: RTL and testbench

Sequencer for an external bank of WIDTH T flip-flops (each with its own clk/rst, T input, Q output). It drives the per-bit T inputs, using Q feedback, to load a start value, count to a terminal value, and stop. It also shadows the commanded value and flags any flop that fails to follow its T command. It sits between the top-level control logic and the T flip-flop datapath.

---
 rtl/tff_count_ctrl_if.sv | 27 ++
 rtl/tff_count_ctrl.sv | 153 +++++++++++++++
 tb/tb_tff_count_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tff_count_ctrl_if.sv
// tff_count_ctrl_if: control/status and flop-bank signals of the T flip-flop sequencer.
// master: top-level control side (also carries the flop bank's Q back in).
// slave: the sequencer itself.
interface tff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             hold;
    logic             up;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_en;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, stop, hold, up, limit, q,
        input  t_en, busy, done, err
    );

    modport slave (
        input  start, stop, hold, up, limit, q,
        output t_en, busy, done, err
    );
endinterface

// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: drives the T inputs of an external bank of WIDTH T flip-flops so the
// bank loads a start value, counts to a terminal value and stops, while shadowing the
// commanded value and flagging any flop that does not follow its T command.
// Optional build macro TFF_CTRL_DOWN_EN enables down counting (direction latched from up).
//
// state | meaning
// IDLE  | waiting for start, t_en=0
// LOAD  | one edge that toggles the bank onto the start value
// RUN   | counting toward the terminal value (hold pauses, stop aborts)
// DONE  | one-cycle completion pulse, then back to IDLE
module tff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    tff_count_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] lim_r;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] cnt_mask;
    logic [WIDTH-1:0] t_en;
    logic [WIDTH-1:0] shadow;
    logic             chk;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             accept;

    assign accept = (state == IDLE) && bus.start;

`ifdef TFF_CTRL_DOWN_EN
    logic dir_r;

    // Direction is captured together with the limit on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_r <= 1'b1;
        end else if (accept) begin
            dir_r <= bus.up;
        end
    end

    assign target = dir_r ? '0 : lim_r;
    assign term   = dir_r ? lim_r : '0;

    // Ripple toggle mask: a bit toggles when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        logic up_c;
        logic dn_c;
        cnt_mask = '0;
        up_c     = 1'b1;
        dn_c     = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_mask[i] = dir_r ? up_c : dn_c;
            up_c        = up_c & bus.q[i];
            dn_c        = dn_c & ~bus.q[i];
        end
    end
`else
    logic unused_up;

    assign unused_up = bus.up;
    assign target    = '0;
    assign term      = lim_r;

    // Ripple toggle mask for an up counter: a bit toggles when all lower bits are 1.
    always_comb begin
        logic up_c;
        cnt_mask = '0;
        up_c     = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_mask[i] = up_c;
            up_c        = up_c & bus.q[i];
        end
    end
`endif

    // State register plus registered status flags and the limit latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            lim_r  <= '0;
        end else begin
            state  <= state_nxt;
            busy_r <= (state_nxt == LOAD) || (state_nxt == RUN);
            done_r <= (state_nxt == DONE);
            if (accept) begin
                lim_r <= bus.limit;
            end
        end
    end

    // Next state and T commands; the terminal compare runs before any increment so no wrap.
    always_comb begin
        state_nxt = state;
        t_en      = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                t_en      = bus.q ^ target;
                state_nxt = bus.stop ? IDLE : RUN;
            end
            RUN: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (bus.q == term) begin
                    state_nxt = DONE;
                end else if (!bus.hold) begin
                    t_en = cnt_mask;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shadow of the commanded Q; a flop that missed its toggle sets the sticky err.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            chk    <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            shadow <= bus.q ^ t_en;
            chk    <= (state == LOAD) || (state == RUN);
            if (accept) begin
                err_r <= 1'b0;
            end else if (chk && (bus.q != shadow)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.t_en = t_en;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: T flip-flop bank model plus scoreboard for the q sequence and done timing.
module tb_tff_count_ctrl;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] stuck = '0;
    int               cyc = 0;
    int               n_tests = 0;
    int               n_fail = 0;
    bit               q_mon_en = 1'b1;
    logic             busy_d = 1'b0;
    int               exp_q[$];
    int               exp_done[$];

    tff_count_ctrl_if #(.WIDTH(WIDTH)) bus ();

    tff_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Flop bank: each bit toggles on T, stuck bits are forced to 0.
    always @(posedge clk) begin
        if (rst) bus.q <= '0;
        else     bus.q <= (bus.q ^ bus.t_en) & ~stuck;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected q for every RUN cycle and the expected cycle of each done.
    always @(negedge clk) begin
        if (q_mon_en && bus.busy && busy_d) begin
            if (exp_q.size() == 0) chk("q_extra", exp_q.size(), 1);
            else                   chk("q_seq", bus.q, exp_q.pop_front());
        end
        if (bus.done) begin
            if (exp_done.size() == 0) chk("done_extra", bus.done, 0);
            else                      chk("done_cycle", cyc, exp_done.pop_front());
        end
        busy_d = bus.busy;
    end

    // One run: abort_at>=0 aborts at that q value, by stop or (use_rst) by reset.
    task automatic run(input int lim, input bit dn, input int hold_at, input int hold_n,
                       input int abort_at, input bit use_rst);
        int  c0;
        int  nbusy;
        int  hl;
        int  v;
        bit  aborted;
        aborted = 1'b0;
        for (int k = 0; k <= lim; k++) begin
            v = dn ? lim - k : k;
            exp_q.push_back(v);
            if (v == hold_at) for (int j = 0; j < hold_n; j++) exp_q.push_back(v);
            if (v == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.limit = WIDTH'(lim);
        bus.up    = ~dn;
        @(negedge clk);
        bus.start = 1'b0;
        c0 = cyc;
        if (!aborted) exp_done.push_back(c0 + lim + 2 + hold_n);
        chk("err_clr", bus.err, 0);
        nbusy = 0;
        hl    = hold_n;
        for (int k = 0; k < 200; k++) begin
            if (!bus.busy) break;
            nbusy++;
            if (k > 0 && bus.q == abort_at) begin
                if (use_rst) rst = 1'b1;
                else         bus.stop = 1'b1;
            end
            if (k > 0 && bus.q == hold_at && hl > 0) begin
                bus.hold = 1'b1;
                hl--;
            end
            #1;
            if (bus.stop || bus.hold) chk("t_en_forced0", bus.t_en, 0);
            @(negedge clk);
            bus.stop = 1'b0;
            bus.hold = 1'b0;
            rst      = 1'b0;
        end
        chk("busy_end", bus.busy, 0);
        chk("t_en_after", bus.t_en, 0);
        if (!aborted) begin
            chk("busy_cycles", nbusy, lim + 2 + hold_n);
            chk("q_final", bus.q, dn ? 0 : lim);
            chk("err_run", bus.err, 0);
        end else if (use_rst) begin
            chk("rst_q", bus.q, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_err", bus.err, 0);
        end else begin
            chk("abort_q", bus.q, abort_at);
            chk("abort_done", bus.done, 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.hold  = 1'b0;
        bus.up    = 1'b1;
        bus.limit = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done0", bus.done, 0);
        chk("rst_err0", bus.err, 0);
        chk("rst_t_en", bus.t_en, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_q", bus.q, 0);

        run(5, 1'b0, -1, 0, -1, 1'b0);
        run(6, 1'b0, 2, 3, -1, 1'b0);
        run(6, 1'b0, -1, 0, 4, 1'b0);
        run(2, 1'b0, -1, 0, -1, 1'b0);
`ifdef TFF_CTRL_DOWN_EN
        run(3, 1'b0, -1, 0, -1, 1'b0);
        run(9, 1'b1, -1, 0, -1, 1'b0);
`endif

        // Bit 1 stuck at 0: the toggle into q=2 is missed at E3, err rises after E4.
        q_mon_en = 1'b0;
        stuck    = 4'b0010;
        @(negedge clk);
        bus.start = 1'b1;
        bus.limit = 4'd7;
        bus.up    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_before", bus.err, 0);
        @(negedge clk);
        chk("err_set", bus.err, 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", bus.err, 1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("fault_abort_busy", bus.busy, 0);
        chk("err_idle", bus.err, 1);
        stuck    = '0;
        @(negedge clk);
        q_mon_en = 1'b1;
        busy_d   = 1'b0;

        run(2, 1'b0, -1, 0, -1, 1'b0);
        run(0, 1'b0, -1, 0, -1, 1'b0);
        run(6, 1'b0, -1, 0, 3, 1'b1);
        repeat (3) @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_t_en", bus.t_en, 0);
        chk("post_rst_q", bus.q, 0);

        chk("q_left", exp_q.size(), 0);
        chk("done_left", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
